// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter: the CPU and a memory loader share one
// synchronous RAM port, with a starvation guard that protects the loader.
module ram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mw,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       ld_req,
    input  logic       ld_we,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_wdata,
    output logic       ld_ack,
    output logic [7:0] ld_rdata,
    output logic       ram_en,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       cpu_hold,
    output logic [1:0] owner
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_ACK,
        LD_ACC,
        LD_ACK
    } state_t;

    localparam logic [31:0] STARVE_LIM = 32'(STARVE_MAX);
    localparam logic [1:0]  OWN_NONE   = 2'd0;
    localparam logic [1:0]  OWN_CPU    = 2'd1;
    localparam logic [1:0]  OWN_LD     = 2'd2;

    state_t      state_q;
    logic [2:0]  starve_cnt_q;
    logic        ram_en_q;
    logic        ram_we_q;
    logic [7:0]  ram_addr_q;
    logic [7:0]  ram_wdata_q;
    logic        cpu_ack_q;
    logic        ld_ack_q;
    logic [7:0]  cpu_rdata_q;
    logic [7:0]  ld_rdata_q;
    logic [1:0]  owner_q;
    logic        cpu_hold_q;

    logic        starved_d;
    logic        ld_win_d;
    logic        cpu_win_d;

    // Arbitration decision, only consumed while the FSM is in IDLE
    always_comb begin
        starved_d = 1'b0;
        ld_win_d  = 1'b0;
        cpu_win_d = 1'b0;
        starved_d = ({29'd0, starve_cnt_q} >= STARVE_LIM);
        ld_win_d  = ld_req & (mw | ~cpu_req | starved_d);
        cpu_win_d = cpu_req & ~mw & ~ld_win_d;
    end

    // Transaction FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= 3'd0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= 8'd0;
            ram_wdata_q  <= 8'd0;
            cpu_ack_q    <= 1'b0;
            ld_ack_q     <= 1'b0;
            cpu_rdata_q  <= 8'd0;
            ld_rdata_q   <= 8'd0;
            owner_q      <= OWN_NONE;
            cpu_hold_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ld_win_d) begin
                        state_q      <= LD_ACC;
                        ram_en_q     <= 1'b1;
                        ram_we_q     <= ld_we;
                        ram_addr_q   <= ld_addr;
                        ram_wdata_q  <= ld_wdata;
                        owner_q      <= OWN_LD;
                        cpu_hold_q   <= 1'b1;
                        starve_cnt_q <= 3'd0;
                    end else if (cpu_win_d) begin
                        state_q      <= CPU_ACC;
                        ram_en_q     <= 1'b1;
                        ram_we_q     <= cpu_we;
                        ram_addr_q   <= cpu_addr;
                        ram_wdata_q  <= cpu_wdata;
                        owner_q      <= OWN_CPU;
                        cpu_hold_q   <= mw;
                        if (ld_req && starve_cnt_q != 3'd7) begin
                            starve_cnt_q <= starve_cnt_q + 3'd1;
                        end
                    end else begin
                        owner_q    <= OWN_NONE;
                        cpu_hold_q <= mw;
                    end
                end
                CPU_ACC: begin
                    state_q    <= CPU_ACK;
                    ram_en_q   <= 1'b0;
                    ram_we_q   <= 1'b0;
                    cpu_ack_q  <= 1'b1;
                    cpu_hold_q <= mw;
                end
                CPU_ACK: begin
                    state_q     <= IDLE;
                    cpu_ack_q   <= 1'b0;
                    cpu_rdata_q <= ram_rdata;
                    owner_q     <= OWN_NONE;
                    cpu_hold_q  <= mw;
                end
                LD_ACC: begin
                    state_q    <= LD_ACK;
                    ram_en_q   <= 1'b0;
                    ram_we_q   <= 1'b0;
                    ld_ack_q   <= 1'b1;
                    cpu_hold_q <= 1'b1;
                end
                LD_ACK: begin
                    state_q    <= IDLE;
                    ld_ack_q   <= 1'b0;
                    ld_rdata_q <= ram_rdata;
                    owner_q    <= OWN_NONE;
                    cpu_hold_q <= mw;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The RAM's own output register feeds the ack cycle directly; the
    // local copy holds the value once ack drops.
    always_comb begin
        ram_en    = ram_en_q;
        ram_we    = ram_we_q;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        cpu_ack   = cpu_ack_q;
        ld_ack    = ld_ack_q;
        cpu_rdata = cpu_ack_q ? ram_rdata : cpu_rdata_q;
        ld_rdata  = ld_ack_q ? ram_rdata : ld_rdata_q;
        owner     = owner_q;
        cpu_hold  = cpu_hold_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized rounds checked
// against a transaction-level model of the arbitration rules and the RAM.
module tb_ram_arbiter;

    localparam int SMAX = 4;

    logic       clk = 1'b0;
    logic       reset, mw;
    logic       cpu_req, cpu_we, ld_req, ld_we;
    logic [7:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic       cpu_ack, ld_ack, ram_en, ram_we, cpu_hold;
    logic [7:0] cpu_rdata, ld_rdata, ram_addr, ram_wdata;
    logic [7:0] ram_rdata = 8'd0;
    logic [1:0] owner;

    logic [7:0] mem  [256];
    logic [7:0] gold [256];

    int checks = 0;
    int failures = 0;

    ram_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .mw(mw),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .cpu_hold(cpu_hold), .owner(owner)
    );

    always #5 clk = ~clk;

    // Synchronous read-first RAM
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic idle_inputs();
        mw = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mw = 1; cpu_req = 1; ld_req = 1; cpu_we = 1; ld_we = 1;
        cpu_addr = 8'h55; ld_addr = 8'h66;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got=%b want=0", ram_en); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b want=0", ram_we); end
        checks++; if ({ram_addr, ram_wdata} !== 16'h0) begin failures++; $display("FAIL reset_ram_bus got=%h want=0000", {ram_addr, ram_wdata}); end
        checks++; if ({cpu_ack, ld_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b want=00", {cpu_ack, ld_ack}); end
        checks++; if ({cpu_rdata, ld_rdata} !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0000", {cpu_rdata, ld_rdata}); end
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d want=0", owner); end
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL reset_cpu_hold got=%b want=0", cpu_hold); end
        #1 reset = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        apply_reset();
        mem[8'h10] = 8'hA5; gold[8'h10] = 8'hA5;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL rd_idle_en got=%b want=0", ram_en); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({ram_en, ram_we} !== 2'b10) begin failures++; $display("FAIL rd_acc_en_we got=%b want=10", {ram_en, ram_we}); end
        checks++; if (ram_addr !== 8'h10) begin failures++; $display("FAIL rd_acc_addr got=%h want=10", ram_addr); end
        checks++; if (owner !== 2'd1) begin failures++; $display("FAIL rd_acc_owner got=%0d want=1", owner); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({cpu_ack, ld_ack, ram_en} !== 3'b100) begin failures++; $display("FAIL rd_ack got=%b want=100", {cpu_ack, ld_ack, ram_en}); end
        checks++; if (cpu_rdata !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h want=a5", cpu_rdata); end
        @(posedge clk); #1 cpu_req = 0; @(negedge clk);
        checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_pulse got=%b want=0", cpu_ack); end
        checks++; if (cpu_rdata !== 8'hA5) begin failures++; $display("FAIL rd_hold got=%h want=a5", cpu_rdata); end
    endtask

    task automatic test_loader_manual();
        apply_reset();
        mw = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({owner, ram_en, cpu_hold} !== 4'b0001) begin failures++; $display("FAIL mw_idle got=%b want=0001", {owner, ram_en, cpu_hold}); end
        ld_req = 1; ld_we = 1; ld_addr = 8'h03; ld_wdata = 8'h3C;
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({ram_en, ram_we} !== 2'b11) begin failures++; $display("FAIL mw_acc_en_we got=%b want=11", {ram_en, ram_we}); end
        checks++; if ({ram_addr, ram_wdata} !== 16'h033C) begin failures++; $display("FAIL mw_acc_bus got=%h want=033c", {ram_addr, ram_wdata}); end
        checks++; if ({owner, cpu_hold} !== 3'b101) begin failures++; $display("FAIL mw_acc_own_hold got=%b want=101", {owner, cpu_hold}); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({cpu_ack, ld_ack, cpu_hold} !== 3'b011) begin failures++; $display("FAIL mw_ack got=%b want=011", {cpu_ack, ld_ack, cpu_hold}); end
        @(posedge clk); #1 ld_req = 0; @(negedge clk);
        checks++; if ({owner, cpu_ack, ld_ack, cpu_hold} !== 5'b00001) begin failures++; $display("FAIL mw_after got=%b want=00001", {owner, cpu_ack, ld_ack, cpu_hold}); end
        checks++; if (mem[8'h03] !== 8'h3C) begin failures++; $display("FAIL mw_ram_write got=%h want=3c", mem[8'h03]); end
        gold[8'h03] = 8'h3C;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_starvation();
        logic [1:0] seen [$];
        apply_reset();
        cpu_req = 1; ld_req = 1; cpu_addr = 8'h40; ld_addr = 8'h41;
        for (int t = 0; t < 60 && seen.size() < 10; t++) begin
            @(negedge clk);
            if (ram_en) seen.push_back(owner);
        end
        checks++; if (seen.size() != 10) begin failures++; $display("FAIL starve_grants got=%0d want=10", seen.size()); end
        for (int i = 0; i < seen.size(); i++) begin
            automatic logic [1:0] want = (i % (SMAX + 1) == SMAX) ? 2'd2 : 2'd1;
            checks++; if (seen[i] !== want) begin failures++; $display("FAIL starve_grant%0d got=%0d want=%0d", i, seen[i], want); end
        end
        idle_inputs();
    endtask

    task automatic test_mode_change();
        logic [7:0] a, d, b;
        apply_reset();
        a = 8'($urandom); d = 8'($urandom); b = 8'($urandom);
        cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
        ld_req = 1; ld_we = 0; ld_addr = b;
        @(posedge clk); #1 mw = 1; @(negedge clk);
        checks++; if (owner !== 2'd1) begin failures++; $display("FAIL mc_owner_cpu got=%0d want=1", owner); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({cpu_ack, ld_ack} !== 2'b10) begin failures++; $display("FAIL mc_cpu_ack got=%b want=10", {cpu_ack, ld_ack}); end
        gold[a] = d;
        @(posedge clk); #1 cpu_req = 0;
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({owner, ram_addr} !== {2'd2, b}) begin failures++; $display("FAIL mc_ld_grant got=%h want=%h", {owner, ram_addr}, {2'd2, b}); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({ld_ack, ld_rdata} !== {1'b1, gold[b]}) begin failures++; $display("FAIL mc_ld_ack got=%h want=%h", {ld_ack, ld_rdata}, {1'b1, gold[b]}); end
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ld_req = 1; ld_we = 0; ld_addr = 8'h77;
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({owner, ram_en} !== 3'b101) begin failures++; $display("FAIL rm_in_acc got=%b want=101", {owner, ram_en}); end
        reset = 1;
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({ram_en, ld_ack, owner, cpu_hold} !== 5'b00000) begin failures++; $display("FAIL rm_abort got=%b want=00000", {ram_en, ld_ack, owner, cpu_hold}); end
        ld_req = 0; reset = 0;
        @(posedge clk); #1; @(negedge clk);
        checks++; if ({ld_ack, owner} !== 3'b000) begin failures++; $display("FAIL rm_no_ack got=%b want=000", {ld_ack, owner}); end
    endtask

    task automatic test_back_to_back();
        int ack_t [2];
        int n = 0;
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h5A;
        for (int t = 0; t < 20 && n < 2; t++) begin
            @(negedge clk);
            if (cpu_ack) begin ack_t[n] = t; n++; end
        end
        checks++; if (n != 2) begin failures++; $display("FAIL b2b_acks got=%0d want=2", n); end
        else begin
            checks++; if (ack_t[0] != 2) begin failures++; $display("FAIL b2b_first got=%0d want=2", ack_t[0]); end
            checks++; if (ack_t[1] - ack_t[0] != 3) begin failures++; $display("FAIL b2b_spacing got=%0d want=3", ack_t[1] - ack_t[0]); end
        end
        idle_inputs();
    endtask

    // Randomized rounds: the model picks a winner from the stated rules,
    // tracks loader losses, and predicts RAM contents and held read data.
    task automatic test_random();
        int starve = 0;
        logic m, lw, cw, we;
        logic [7:0] a, wd, exp_rd, last_c, last_l;
        apply_reset();
        last_c = 0; last_l = 0;
        for (int r = 0; r < 80; r++) begin
            m = ($urandom_range(0, 3) == 0);
            if (!cpu_req) begin
                cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom);
                cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
            end
            if (!ld_req) begin
                ld_req = 1'($urandom_range(0, 1)); ld_we = 1'($urandom);
                ld_addr = 8'($urandom); ld_wdata = 8'($urandom);
            end
            if (m || !cpu_req) ld_req = 1;
            mw = m;
            lw = ld_req && (m || !cpu_req || starve >= SMAX);
            cw = !lw && cpu_req && !m;
            we = lw ? ld_we : cpu_we;
            a  = lw ? ld_addr : cpu_addr;
            wd = lw ? ld_wdata : cpu_wdata;
            exp_rd = gold[a];
            if (we) gold[a] = wd;
            if (lw) starve = 0;
            else if (ld_req && starve < 7) starve++;
            @(negedge clk);
            checks++; if ({owner, cpu_ack, ld_ack} !== 4'b0000) begin failures++; $display("FAIL rnd%0d_idle got=%b want=0000", r, {owner, cpu_ack, ld_ack}); end
            checks++; if ({cpu_rdata, ld_rdata} !== {last_c, last_l}) begin failures++; $display("FAIL rnd%0d_hold got=%h want=%h", r, {cpu_rdata, ld_rdata}, {last_c, last_l}); end
            @(posedge clk); #1; @(negedge clk);
            checks++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, we, a, wd}) begin failures++; $display("FAIL rnd%0d_acc got=%h want=%h", r, {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, we, a, wd}); end
            checks++; if ({owner, cpu_hold} !== {lw ? 2'd2 : 2'd1, m | lw}) begin failures++; $display("FAIL rnd%0d_own got=%b want=%b", r, {owner, cpu_hold}, {lw ? 2'd2 : 2'd1, m | lw}); end
            @(posedge clk); #1; @(negedge clk);
            checks++; if ({ram_en, cpu_ack, ld_ack} !== {1'b0, cw, lw}) begin failures++; $display("FAIL rnd%0d_ack got=%b want=%b", r, {ram_en, cpu_ack, ld_ack}, {1'b0, cw, lw}); end
            if (lw) last_l = exp_rd; else last_c = exp_rd;
            checks++; if ({cpu_rdata, ld_rdata} !== {last_c, last_l}) begin failures++; $display("FAIL rnd%0d_rdata got=%h want=%h", r, {cpu_rdata, ld_rdata}, {last_c, last_l}); end
            @(posedge clk); #1;
            if (lw) ld_req = 0; else cpu_req = 0;
        end
        idle_inputs();
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== gold[i]) begin
                checks++; failures++;
                $display("FAIL rnd_mem[%0d] got=%h want=%h", i, mem[i], gold[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            gold[i] = mem[i];
        end
        test_reset();
        test_cpu_read();
        test_loader_manual();
        test_starvation();
        test_mode_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive loader losses after which the loader wins the next arbitration.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mw  input  1  manual-write mode; 1 = loader exclusive, 0 = CPU run mode.
REQ-005 SHALL have port cpu_req  input  1  CPU request; level, held until cpu_ack.
REQ-006 SHALL have port cpu_we  input  1  CPU write enable (1 = write, 0 = read).
REQ-007 SHALL have port cpu_addr  input  8  CPU RAM address.
REQ-008 SHALL have port cpu_wdata  input  8  CPU write data.
REQ-009 SHALL have port cpu_ack  output  1  one-cycle completion pulse to the CPU.
REQ-010 SHALL have port cpu_rdata  output  8  CPU read data; valid while cpu_ack = 1.
REQ-011 SHALL have port ld_req, ld_we, ld_addr[8], ld_wdata[8]  input  loader request, with the same meaning as the cpu_* inputs.
REQ-012 SHALL have port ld_ack  output  1  and port ld_rdata  output  8  loader completion pulse and loader read data.
REQ-013 SHALL have port ram_en  output  1  RAM access strobe.
REQ-014 SHALL have port ram_we  output  1  RAM write enable.
REQ-015 SHALL have port ram_addr  output  8  and port ram_wdata  output  8  RAM address and RAM write data.
REQ-016 SHALL have port ram_rdata  input  8  RAM read data; registered, valid one cycle after ram_en.
REQ-017 SHALL have port cpu_hold  output  1  stalls the CPU clock enable.
REQ-018 SHALL have port owner  output  2  current owner: 0 = none, 1 = CPU, 2 = loader.

Function
REQ-019 SHALL implement FSM states IDLE, CPU_ACC, CPU_ACK, LD_ACC, LD_ACK; all outputs SHALL be registered.
REQ-020 SHALL arbitrate only in IDLE; in that cycle it latches the winner's we/addr/wdata and moves to CPU_ACC or LD_ACC.
REQ-021 SHALL, in X_ACC, drive ram_en = 1, ram_we = latched we, ram_addr and ram_wdata = latched values, then move to X_ACK.
REQ-022 SHALL, in X_ACK, pulse the winner's ack for exactly one cycle with x_rdata = ram_rdata, drive ram_en = 0, and return to IDLE.
REQ-023 SHALL deliver ack 2 cycles after a request is sampled in IDLE; throughput SHALL be one transaction per 3 cycles.
REQ-024 SHALL treat a req still high in the IDLE cycle after ack as a new transaction; requesters deassert req on the cycle after ack.
REQ-025 SHALL, when mw = 1, grant only the loader and ignore cpu_req.
REQ-026 SHALL, when mw = 0, grant the CPU when cpu_req = 1, except that the loader SHALL win when ld_req = 1 and starve_cnt >= STARVE_MAX.
REQ-027 SHALL grant the loader when mw = 0, cpu_req = 0 and ld_req = 1.
REQ-028 starve_cnt SHALL be a 3-bit counter that:
- increments when ld_req = 1 and the CPU wins;
- saturates at 7;
- clears on any loader grant.
REQ-029 SHALL hold cpu_hold = 1 when mw = 1, or in state LD_ACC or LD_ACK; otherwise cpu_hold = 0.
REQ-030 SHALL set owner to 1 in CPU_* states, 2 in LD_* states, and 0 in IDLE.
REQ-031 SHALL ignore a change of mw during a transaction; the transaction completes and the new mode applies at the next IDLE decision.
REQ-032 SHALL keep rdata outputs holding their last value when ack = 0; write transactions SHALL also update x_rdata with ram_rdata (don't-care to requesters).
REQ-033 SHALL never assert cpu_ack and ld_ack in the same cycle.

Reset
REQ-034 SHALL, on reset = 1 at a clock edge, set state = IDLE, starve_cnt = 0, ram_en/ram_we/ram_addr/ram_wdata = 0, cpu_ack/ld_ack = 0, cpu_rdata/ld_rdata = 0, owner = 0, and cpu_hold = 0.
REQ-035 SHALL abort an in-flight transaction on reset without issuing an ack; arbitration resumes on the first edge after reset deasserts.

Verification
REQ-036 SHALL be verified for a CPU read: mw = 0, cpu_req = 1, cpu_we = 0, cpu_addr = 0x10, RAM[0x10] = 0xA5 -> ram_en pulses in cycle +1 with ram_addr = 0x10, and cpu_ack pulses in cycle +2 with cpu_rdata = 0xA5.
REQ-037 SHALL be verified for a loader write in manual mode: mw = 1, ld_req = 1, ld_we = 1, ld_addr = 0x03, ld_wdata = 0x3C, with cpu_req also 1 -> only the loader is served, ram_we = 1, ram_wdata = 0x3C, ld_ack fires, and cpu_hold = 1 throughout.
REQ-038 SHALL be verified for starvation: mw = 0, cpu_req and ld_req held continuously -> the CPU wins 4 consecutive grants, the 5th grant goes to the loader, and starve_cnt returns to 0.
REQ-039 SHALL be verified for a mode change mid-transaction: a CPU write in CPU_ACC and mw rises -> cpu_ack still fires, and the next grant goes to the loader.
REQ-040 SHALL be verified for reset mid-transaction: reset in LD_ACC -> the next cycle shows ram_en = 0, no ld_ack, owner = 0, and cpu_hold = 0.
REQ-041 SHALL be verified for back-to-back requests: cpu_req held high through ack -> a second transaction starts in the IDLE cycle after ack, with acks spaced 3 cycles apart.
